// File: rtl/unified_mem_ctrl.sv
// Purpose: shares one single-ported, fixed-latency unified memory between the fetch and data ports.
// Latency: request seen in IDLE at cycle 0 -> m_en at cycle 1 -> m_rdata captured at 1+LAT -> ack at 2+LAT.
// Backpressure: requesters hold req until their one-cycle ack; one access per LAT+3 cycles, stall = req & ~ack.
//
// Ports:
//   clk, rst                    : rising-edge clock, asynchronous active-low reset
//   if_req/if_addr              : fetch request (level) and byte address
//   if_ack/if_rdata/if_stall    : fetch ack pulse, fetched word, PC freeze
//   d_req/d_we/d_addr/d_wdata   : data request (level), store flag, byte address, store data
//   d_ack/d_rdata/d_stall       : data ack pulse, load data, pipeline freeze
//   m_en/m_we/m_addr/m_wdata    : memory strobe (one cycle per access), write enable, word address, write data
//   m_rdata                     : memory read data, valid LAT cycles after m_en
//
// Build option: define UNIFIED_MEM_CTRL_RR_EN for round-robin arbitration; otherwise data wins over fetch.
module unified_mem_ctrl #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-3:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       win_d;   // latched winner: 1 = data port, 0 = fetch port
  logic       win_we;  // latched store flag of the winner
  logic       grant_d; // data port wins if a request is taken this cycle

  // Byte-offset bits are dropped by design.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{if_addr[1:0], d_addr[1:0]};

  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

`ifdef UNIFIED_MEM_CTRL_RR_EN
  logic rr_ptr; // 0 = fetch has priority on a collision, 1 = data

  assign grant_d = d_req & (~if_req | rr_ptr);

  // The pointer moves to the served port whenever the port it named was not
  // the one served, so it only changes after an access by the other side.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= 1'b0;
    end else if (state == RESP && win_d != rr_ptr) begin
      rr_ptr <= ~rr_ptr;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      win_d    <= 1'b0;
      win_we   <= 1'b0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            // Winner fields are frozen here until the access retires.
            state  <= ISSUE;
            m_en   <= 1'b1;
            win_d  <= grant_d;
            win_we <= grant_d & d_we;
            m_we   <= grant_d & d_we;
            m_addr <= grant_d ? d_addr[AW-1:2] : if_addr[AW-1:2];
            if (grant_d) m_wdata <= d_wdata;
          end
        end
        ISSUE: begin
          m_en  <= 1'b0;
          m_we  <= 1'b0;
          cnt   <= 4'(LAT);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // cnt == 1 marks the cycle in which m_rdata is valid.
          if (cnt == 4'd1) begin
            if (!win_we) begin
              if (win_d) d_rdata  <= m_rdata;
              else       if_rdata <= m_rdata;
            end
            d_ack  <= win_d;
            if_ack <= ~win_d;
            state  <= RESP;
          end
        end
        RESP: begin
          d_ack  <= 1'b0;
          if_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
module tb_unified_mem_ctrl;
  localparam int N = 3;

  logic        clk, rst;
  logic        if_req_a   [N];
  logic [31:0] if_addr_a  [N];
  logic        if_ack_a   [N];
  logic [31:0] if_rdata_a [N];
  logic        if_stall_a [N];
  logic        d_req_a    [N];
  logic        d_we_a     [N];
  logic [31:0] d_addr_a   [N];
  logic [31:0] d_wdata_a  [N];
  logic        d_ack_a    [N];
  logic [31:0] d_rdata_a  [N];
  logic        d_stall_a  [N];
  logic        m_en_a     [N];
  logic        m_we_a     [N];
  logic [29:0] m_addr_a   [N];
  logic [31:0] m_wdata_a  [N];
  logic [31:0] m_rdata_a  [N];

  // Reference model: word-addressed memory image plus expected rdata registers.
  logic [31:0] ref_mem [N][256];
  logic [31:0] exp_if  [N];
  logic [31:0] exp_d   [N];
  int n_chk, n_pass, n_fail;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 32'h2008_0005;
    return {a, 8'h5A, ~a, a ^ 8'h33};
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int L = lat_of(g);
    logic [31:0] mem [256];
    logic [31:0] rd_val;
    int          rd_cnt;

    initial for (int i = 0; i < 256; i++) mem[i] = init_word(8'(i));

    // Fixed-latency memory: data is driven only in the single valid cycle.
    always @(posedge clk) begin
      if (m_en_a[g]) begin
        if (m_we_a[g]) mem[m_addr_a[g][7:0]] <= m_wdata_a[g];
        else begin
          rd_val <= mem[m_addr_a[g][7:0]];
          rd_cnt <= L;
        end
      end else if (rd_cnt != 0) begin
        rd_cnt <= rd_cnt - 1;
      end
    end
    assign m_rdata_a[g] = (rd_cnt == 1) ? rd_val : 32'hBADB_AD00;

    unified_mem_ctrl #(.AW(32), .DW(32), .LAT(L)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req_a[g]),
      .if_addr  (if_addr_a[g]),
      .if_ack   (if_ack_a[g]),
      .if_rdata (if_rdata_a[g]),
      .if_stall (if_stall_a[g]),
      .d_req    (d_req_a[g]),
      .d_we     (d_we_a[g]),
      .d_addr   (d_addr_a[g]),
      .d_wdata  (d_wdata_a[g]),
      .d_ack    (d_ack_a[g]),
      .d_rdata  (d_rdata_a[g]),
      .d_stall  (d_stall_a[g]),
      .m_en     (m_en_a[g]),
      .m_we     (m_we_a[g]),
      .m_addr   (m_addr_a[g]),
      .m_wdata  (m_wdata_a[g]),
      .m_rdata  (m_rdata_a[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on instance g; addr2 replaces the port address from cycle 2 on.
  task automatic do_access(input int g, input logic port, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] addr2);
    int lat, ack_k, n_en, en_k, wrong_ack;
    logic stall_pre, ack_stall, en_we;
    logic [29:0] en_maddr, ack_maddr;
    logic [31:0] en_wd;
    logic [7:0] widx;
    lat = lat_of(g);
    ack_k = 0; n_en = 0; en_k = 0; wrong_ack = 0;
    stall_pre = 1'b0; ack_stall = 1'b1; en_we = 1'b0;
    en_maddr = '0; ack_maddr = '0; en_wd = '0;
    widx = addr[9:2];
    @(negedge clk);
    if (port) begin
      d_req_a[g] = 1'b1; d_we_a[g] = we; d_addr_a[g] = addr; d_wdata_a[g] = wdata;
    end else begin
      if_req_a[g] = 1'b1; if_addr_a[g] = addr;
    end
    #1;
    chk("stall_cycle0", 32'(port ? d_stall_a[g] : if_stall_a[g]), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (m_en_a[g]) begin
        n_en++; en_k = k; en_maddr = m_addr_a[g]; en_we = m_we_a[g]; en_wd = m_wdata_a[g];
      end
      if (k == lat + 1) stall_pre = port ? d_stall_a[g] : if_stall_a[g];
      if (port ? if_ack_a[g] : d_ack_a[g]) wrong_ack++;
      if (k == 2) begin
        if (port) d_addr_a[g] = addr2;
        else      if_addr_a[g] = addr2;
      end
      if (port ? d_ack_a[g] : if_ack_a[g]) begin
        ack_k = k; ack_maddr = m_addr_a[g];
        ack_stall = port ? d_stall_a[g] : if_stall_a[g];
        break;
      end
    end
    if (port) d_req_a[g] = 1'b0;
    else      if_req_a[g] = 1'b0;

    if (port && we)  ref_mem[g][widx] = wdata;
    else if (port)   exp_d[g]  = ref_mem[g][widx];
    else             exp_if[g] = ref_mem[g][widx];

    chk("ack_cycle",   32'(ack_k), 32'(lat + 2));
    chk("m_en_count",  32'(n_en), 32'd1);
    chk("m_en_cycle",  32'(en_k), 32'd1);
    chk("m_addr",      32'(en_maddr), 32'(addr[31:2]));
    chk("m_addr_held", 32'(ack_maddr), 32'(addr[31:2]));
    chk("m_we",        32'(en_we), 32'(port & we));
    if (port && we) chk("m_wdata", en_wd, wdata);
    chk("stall_before_ack", 32'(stall_pre), 32'd1);
    chk("stall_at_ack",     32'(ack_stall), 32'd0);
    chk("other_port_ack",   32'(wrong_ack), 32'd0);
    chk("if_rdata", if_rdata_a[g], exp_if[g]);
    chk("d_rdata",  d_rdata_a[g],  exp_d[g]);
  endtask

  // Fetch of 0x40 and load of 0x100 raised together on instance 0.
  task automatic collide(input int e_d, input int e_if);
    int dk, ik;
    dk = 0; ik = 0;
    @(negedge clk);
    if_req_a[0] = 1'b1; if_addr_a[0] = 32'h40;
    d_req_a[0] = 1'b1; d_we_a[0] = 1'b0; d_addr_a[0] = 32'h100;
    for (int k = 1; k <= 40 && (dk == 0 || ik == 0); k++) begin
      @(negedge clk);
      if (d_ack_a[0]) begin
        dk = k; d_req_a[0] = 1'b0; exp_d[0] = ref_mem[0][8'h40];
        chk("coll_d_rdata", d_rdata_a[0], exp_d[0]);
        if (ik == 0) chk("coll_if_stall", 32'(if_stall_a[0]), 32'd1);
      end
      if (if_ack_a[0]) begin
        ik = k; if_req_a[0] = 1'b0; exp_if[0] = ref_mem[0][8'h10];
        chk("coll_if_rdata", if_rdata_a[0], exp_if[0]);
        if (dk == 0) chk("coll_d_stall", 32'(d_stall_a[0]), 32'd1);
      end
    end
    if_req_a[0] = 1'b0; d_req_a[0] = 1'b0;
    chk("coll_d_ack_cycle",  32'(dk), 32'(e_d));
    chk("coll_if_ack_cycle", 32'(ik), 32'(e_if));
  endtask

  initial begin
    int acks, ens, g;
    logic port, we;
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      if_req_a[i] = 1'b0; if_addr_a[i] = '0; d_req_a[i] = 1'b0; d_we_a[i] = 1'b0;
      d_addr_a[i] = '0; d_wdata_a[i] = '0; exp_if[i] = '0; exp_d[i] = '0;
      for (int j = 0; j < 256; j++) ref_mem[i][j] = init_word(8'(j));
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rst_m_en",     32'(m_en_a[i]), 32'd0);
      chk("rst_m_we",     32'(m_we_a[i]), 32'd0);
      chk("rst_if_ack",   32'(if_ack_a[i]), 32'd0);
      chk("rst_d_ack",    32'(d_ack_a[i]), 32'd0);
      chk("rst_m_addr",   32'(m_addr_a[i]), 32'd0);
      chk("rst_m_wdata",  m_wdata_a[i], 32'd0);
      chk("rst_if_rdata", if_rdata_a[i], 32'd0);
      chk("rst_d_rdata",  d_rdata_a[i], 32'd0);
    end
    rst = 1'b1;

    // Single fetch, store, load back, then address change during WAIT.
    do_access(0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0040);
    do_access(0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100);
    do_access(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0100);
    do_access(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0200);

    // Reset pulse at cycle 2 of a load.
    @(negedge clk);
    d_req_a[0] = 1'b1; d_we_a[0] = 1'b0; d_addr_a[0] = 32'h100;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_d_ack",   32'(d_ack_a[0]), 32'd0);
    chk("midrst_m_en",    32'(m_en_a[0]), 32'd0);
    chk("midrst_d_rdata", d_rdata_a[0], 32'd0);
    d_req_a[0] = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < N; i++) begin exp_if[i] = '0; exp_d[i] = '0; end
    acks = 0; ens = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_ack_a[0] || if_ack_a[0]) acks++;
      if (m_en_a[0]) ens++;
    end
    chk("midrst_no_ack",  32'(acks), 32'd0);
    chk("midrst_no_m_en", 32'(ens), 32'd0);

`ifdef UNIFIED_MEM_CTRL_RR_EN
    collide(9, 4);
    collide(4, 9);
`else
    collide(4, 9);
    collide(4, 9);
`endif
    do_access(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0100);

    // Randomized traffic; instances 1 and 2 sweep LAT = 1 and LAT = 15.
    for (int n = 0; n < 36; n++) begin
      logic [31:0] a;
      g = (n < 24) ? 0 : ((n < 30) ? 1 : 2);
      port = 1'($urandom_range(0, 1));
      we = port ? 1'($urandom_range(0, 1)) : 1'b0;
      a = $urandom & 32'hFFFF_FC3F;
      do_access(g, port, we, a, $urandom, a);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/unified_mem_ctrl.md
# unified_mem_ctrl

Sequencing controller that shares one single-ported, fixed-latency unified memory between the instruction-fetch port and the data-memory port of the MIPS core. It accepts one request at a time and drives the memory-side strobe, address and data. It captures read data after the configured latency and returns a one-cycle acknowledge to the winning port. Its stall outputs freeze the PC and the pipeline while a port waits.

## Interface
Parameters:
- AW, 32: byte-address width of both requester ports
- DW, 32: data width
- LAT, 2: memory read/write latency in cycles from the m_en cycle to valid m_rdata; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  AW  fetch byte address
- if_ack  out  1  one-cycle pulse; if_rdata valid in this cycle
- if_rdata  out  DW  fetched instruction
- if_stall  out  1  if_req & ~if_ack
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data byte address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle pulse; d_rdata valid in this cycle when d_we = 0
- d_rdata  out  DW  load data
- d_stall  out  1  d_req & ~d_ack
- m_en  out  1  memory access strobe, one cycle per access
- m_we  out  1  memory write enable, qualified by m_en
- m_addr  out  AW-2  word address, equal to addr[AW-1:2]
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid LAT cycles after m_en

## Operation
- States:
  - IDLE → ISSUE: when any req is sampled high; the winner is latched (port, we, addr, wdata).
  - ISSUE → WAIT: m_en = 1 for exactly this cycle; the latency counter is loaded with LAT.
  - WAIT: the counter decrements each cycle. At count 1, m_rdata is captured into the winner's rdata register and the FSM goes → RESP.
  - RESP → IDLE: the winner's ack = 1 for this cycle.
- Requests are sampled only in IDLE. A req still high in the IDLE cycle after its ack counts as a new request.
- Arbitration default is fixed priority: d_req wins over if_req. This is safe because the core issues a data access only after its fetch has completed.
- The winner's latched fields are frozen from IDLE exit until RESP. Changes to the inputs during an access are ignored.
- On writes, the rdata registers are not updated. The ack still occurs at the same cycle as for a read.
- rdata registers hold their value between accesses.
- if_rdata and d_rdata are independent registers; an access on one port never alters the other.
- Address bits [1:0] are discarded and are not checked.

## Timing
- Reset values: all state registers clear to IDLE; m_en, m_we, if_ack and d_ack are 0; m_addr, m_wdata, if_rdata and d_rdata are 0; the RR pointer (if compiled in) selects fetch.
- Latency:
  - A request seen in IDLE at cycle 0 gives m_en at cycle 1, captures m_rdata at cycle 1+LAT, and acks at cycle 2+LAT.
  - Throughput is one access per LAT+3 cycles with back-to-back requests.
- All outputs are registered except if_stall and d_stall, which are combinational from req and ack.
- Simultaneous if_req and d_req in IDLE: the winner is chosen by the arbitration rule. The loser's stall stays high and it is served in the next IDLE.
- A req that drops before ack is protocol misuse. The access started still completes and acks, and the ack may be ignored.
- Reset asserted mid-access: the FSM returns to IDLE immediately. m_en and the acks drop asynchronously. No ack is issued for the aborted access.
- LAT = 1: WAIT lasts one cycle; there is no zero-length path.

## Configuration
- Macro UNIFIED_MEM_CTRL_RR_EN.
- Defined: round-robin arbitration. A one-bit pointer flips to the other port after each RESP in which that port was not served. When both ports request, the port named by the pointer wins. The pointer resets to fetch.
- Undefined: fixed data-over-fetch priority; no pointer register exists.

## Test plan
- Reset, then a single fetch. LAT = 2, if_addr = 0x0000_0040, and memory word 0x10 = 0x2008_0005. Required: m_en pulses at cycle 1 with m_addr = 0x10 and m_we = 0; if_ack pulses at cycle 4 with if_rdata = 0x2008_0005; if_stall is high in cycles 0–3.
- Store then load. d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF gives d_ack at cycle 4 and m_we = 1 at cycle 1. The following load from 0x100 returns d_rdata = 0xDEAD_BEEF at its ack.
- Simultaneous if_req and d_req at cycle 0:
  - Default build: d_ack at cycle 4, if_ack at cycle 9.
  - With UNIFIED_MEM_CTRL_RR_EN: fetch is served first. The next collision is served data-first.
- LAT = 1 and LAT = 15 sweep: the ack arrives exactly LAT+2 cycles after the request, and m_en is high for exactly one cycle.
- Async reset pulse at cycle 2 of a load: no d_ack occurs, m_en is 0, and the FSM is in IDLE. A request re-issued after reset release completes normally with the correct data.
- Inputs changed during WAIT (d_addr 0x100 → 0x200): m_addr and the returned data still correspond to 0x100.
